gw5ast_mem_arbiter: RTL and testbench
=====================================

Name: gw5ast_mem_arbiter

Overview:
- Round-robin arbiter that lets N_MASTERS AXI-Lite masters share one gw5ast_memory slave.
- Sits between the per-lane gw5ast_core AXI-Lite master ports and a single shared memory instance.
- Serialises whole transactions: one write (AW+W+B) or one read (AR+R) is outstanding at a time.
- A 1-cycle arbitration stage precedes each transaction.

Parameters:
- N_MASTERS, 8, number of requesting masters (2..16).
- DATA_WIDTH, 24, data bus width.
- ADDR_WIDTH, 16, address bus width.
- IDW, $clog2(N_MASTERS), width of the grant index (derived; not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_awvalid/m_awready  in/out  N_MASTERS  per-master write-address handshake.
- m_awaddr  in  N_MASTERS*ADDR_WIDTH  packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wvalid/m_wready  in/out  N_MASTERS  per-master write-data handshake.
- m_wdata  in  N_MASTERS*DATA_WIDTH  packed write data.
- m_wstrb  in  N_MASTERS*4  packed strobes.
- m_wlast  in  N_MASTERS  per-master wlast.
- m_bvalid/m_bready  out/in  N_MASTERS  per-master write response.
- m_arvalid/m_arready  in/out  N_MASTERS  per-master read address.
- m_araddr  in  N_MASTERS*ADDR_WIDTH  packed read address.
- m_rvalid/m_rready  out/in  N_MASTERS  per-master read data.
- m_bresp  out  2  slave bresp, broadcast to all masters.
- m_rdata  out  DATA_WIDTH  slave rdata, broadcast.
- m_rresp  out  2  slave rresp, broadcast.
- m_rlast  out  1  slave rlast, broadcast.
- s_aw*, s_w*, s_b*, s_ar*, s_r*  mixed  as memory  single AXI-Lite master port to gw5ast_memory, same signal set and widths.
- grant_id  out  IDW  index of the current or last granted master.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, grant_id=0, aw_done=w_done=0.
  - All m_*ready, m_bvalid, m_rvalid, s_*valid, s_bready, s_rready and busy are 0.
  - Rest mid-transaction abandons the transfer immediately; no completion is owed to any master.
- Request: req[i] = m_awvalid[i] | m_arvalid[i].
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP.
- IDLE, arbitration:
  - If any req: winner = first i with req[i] scanning rr_ptr, rr_ptr+1, … mod N_MASTERS.
  - Register grant_id = winner.
  - Next state: WR if m_awvalid[winner], else RD. A write wins over a read from the same master.
  - No slave valid is driven in IDLE. Granted transfers start on the slave the cycle after the request is seen.
- WR:
  - s_awvalid = m_awvalid[g] & ~aw_done; s_awaddr and the W fields are muxed from master g.
  - s_wvalid = m_wvalid[g] & ~w_done.
  - m_awready[g] = s_awready & ~aw_done; m_wready[g] = s_wready & ~w_done.
  - aw_done / w_done set on their respective handshakes. AW and W may complete in either order or in the same cycle.
  - When both are done (including a handshake in the current cycle): go to WR_RESP and clear the flags.
- WR_RESP: m_bvalid[g] = s_bvalid; s_bready = m_bready[g]. On s_bvalid & s_bready: go to IDLE, rr_ptr = g+1 (wraps N_MASTERS-1 to 0).
- RD:
  - s_arvalid = m_arvalid[g]; s_araddr muxed from master g; m_arready[g] = s_arready.
  - On handshake go to RD_RESP.
- RD_RESP: m_rvalid[g] = s_rvalid; s_rready = m_rready[g]. On handshake: go to IDLE, rr_ptr = g+1.
- Ungranted masters always see ready=0, bvalid=0, rvalid=0.
- Slave-side ready/valid outputs are combinational from state, registered flags and the inputs. There are no combinational paths from s_* to s_*.
- Starvation bound: a continuously requesting master is granted within N_MASTERS transactions.
- A read queued behind a write on the same master is re-arbitrated with that master at lowest priority.
- Min transaction latency: 3 cycles (arb, addr/data, response) with a zero-wait slave.
- Master dropping valid before its handshake (AXI violation) is undefined and not checked.
- grant_id holds its value in IDLE when there are no requests.

Test Plan:
- Reset then idle: assert rst 2 cycles, no requests -> busy=0, all m_*ready/m_bvalid/m_rvalid=0, grant_id=0 for 10 cycles.
- Single write: m0 writes addr 0x0010, data 0x123456, wstrb 0xF -> s_awaddr=0x0010 and s_wdata=0x123456 on slave; m_bvalid[0] pulses once; a later read of 0x0010 returns m_rdata=0x123456 on m_rvalid[0].
- Round-robin fairness: masters 0,3,7 hold read requests continuously -> grant order 0,3,7,0,3,7; rr_ptr wraps 7 to 0.
- Write+read same master: m2 asserts awvalid and arvalid together -> write completes first (B), read issued in a later transaction; m5, if requesting, is served in between.
- Split AW/W: slave delays s_wready 3 cycles after the AW handshake -> stays in WR; s_awvalid not re-asserted; B accepted only after W completes.
- Reset mid-read: rst in RD_RESP while s_rvalid=0 -> next cycle all valids=0, state=IDLE, rr_ptr=0; a fresh request from m4 is granted normally.

Source files
------------

// File: rtl/gw5ast_mem_arbiter.sv
// Round-robin AXI-Lite arbiter: N masters share one memory slave, one whole transaction at a time.
// 1-cycle arbitration, then AW/W or AR to the slave; ready/valid pass straight through for the granted master.
module gw5ast_mem_arbiter #(
  parameter int N_MASTERS  = 8,
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16,
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             m_awvalid,
  output logic [N_MASTERS-1:0]             m_awready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_awaddr,
  input  logic [N_MASTERS-1:0]             m_wvalid,
  output logic [N_MASTERS-1:0]             m_wready,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  input  logic [N_MASTERS*4-1:0]           m_wstrb,
  input  logic [N_MASTERS-1:0]             m_wlast,
  output logic [N_MASTERS-1:0]             m_bvalid,
  input  logic [N_MASTERS-1:0]             m_bready,
  input  logic [N_MASTERS-1:0]             m_arvalid,
  output logic [N_MASTERS-1:0]             m_arready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_araddr,
  output logic [N_MASTERS-1:0]             m_rvalid,
  input  logic [N_MASTERS-1:0]             m_rready,
  output logic [1:0]                       m_bresp,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic [1:0]                       m_rresp,
  output logic                             m_rlast,
  output logic                             s_awvalid,
  input  logic                             s_awready,
  output logic [ADDR_WIDTH-1:0]            s_awaddr,
  output logic                             s_wvalid,
  input  logic                             s_wready,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [3:0]                       s_wstrb,
  output logic                             s_wlast,
  input  logic                             s_bvalid,
  output logic                             s_bready,
  input  logic [1:0]                       s_bresp,
  output logic                             s_arvalid,
  input  logic                             s_arready,
  output logic [ADDR_WIDTH-1:0]            s_araddr,
  input  logic                             s_rvalid,
  output logic                             s_rready,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  input  logic [1:0]                       s_rresp,
  input  logic                             s_rlast,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP} state_t;

  state_t                 state;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         winner;
  logic [IDW-1:0]         nxt_ptr;
  logic                   aw_done;
  logic                   w_done;
  logic                   aw_hs;
  logic                   w_hs;
  logic [N_MASTERS-1:0]   req;
  logic [N_MASTERS-1:0]   gsel;

  assign req  = m_awvalid | m_arvalid;
  assign gsel = N_MASTERS'(1) << grant_id;

  // First requester at or after rr_ptr, wrapping modulo N_MASTERS.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(rr_ptr) + k) % N_MASTERS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign nxt_ptr = (grant_id == IDW'(N_MASTERS - 1)) ? '0 : grant_id + 1'b1;

  assign s_awaddr = m_awaddr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_wdata  = m_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign s_wstrb  = m_wstrb[grant_id*4 +: 4];
  assign s_wlast  = m_wlast[grant_id];
  assign s_araddr = m_araddr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];

  assign s_awvalid = (state == WR) & m_awvalid[grant_id] & ~aw_done;
  assign s_wvalid  = (state == WR) & m_wvalid[grant_id] & ~w_done;
  assign s_bready  = (state == WR_RESP) & m_bready[grant_id];
  assign s_arvalid = (state == RD) & m_arvalid[grant_id];
  assign s_rready  = (state == RD_RESP) & m_rready[grant_id];

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  // Only the granted master ever sees a ready or response valid.
  assign m_awready = {N_MASTERS{(state == WR) & s_awready & ~aw_done}} & gsel;
  assign m_wready  = {N_MASTERS{(state == WR) & s_wready & ~w_done}} & gsel;
  assign m_bvalid  = {N_MASTERS{(state == WR_RESP) & s_bvalid}} & gsel;
  assign m_arready = {N_MASTERS{(state == RD) & s_arready}} & gsel;
  assign m_rvalid  = {N_MASTERS{(state == RD_RESP) & s_rvalid}} & gsel;

  assign m_bresp = s_bresp;
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= winner;
            state    <= m_awvalid[winner] ? WR : RD;
          end
        end
        WR: begin
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (s_bvalid && s_bready) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        RD: begin
          if (s_arvalid && s_arready) state <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rvalid && s_rready) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gw5ast_mem_arbiter.sv
// Directed bench: stimulus pushes expected responses into a queue; a monitor pops and compares them.
module tb_gw5ast_mem_arbiter;

  localparam int N  = 8;
  localparam int DW = 24;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [N-1:0]      m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0]   m_awaddr, m_araddr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*4-1:0]    m_wstrb;
  logic [1:0]        m_bresp, m_rresp;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic              s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0]     s_awaddr, s_araddr;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic [2:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  gw5ast_mem_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_bresp(m_bresp), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant_id(grant_id), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          rd;
    int          master;
    logic [23:0] data;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit rd, input int m, input logic [23:0] d);
    exp_t e;
    e.rd = rd; e.master = m; e.data = d;
    expq.push_back(e);
  endtask

  // ---------------- slave memory model ----------------
  logic [23:0] mem [logic [15:0]];
  bit          split_mode = 1'b0;
  int          rdelay = 0;
  int          aw_cnt = 0, aw_reassert = 0, w_stall = 0;
  logic [15:0] last_awaddr;
  logic [23:0] last_wdata;
  logic [3:0]  last_wstrb;

  initial begin
    bit r, awh, wh, bh, arh, rh, got_aw, got_w;
    logic [15:0] saddr, raddr, cap_aw, cap_ar;
    logic [23:0] sdata, cap_w;
    int wcnt, rcnt;
    got_aw = 0; got_w = 0; wcnt = 0; rcnt = -1;
    saddr = '0; raddr = '0; sdata = '0; cap_aw = '0; cap_ar = '0; cap_w = '0;
    s_awready = 1'b1; s_arready = 1'b1; s_wready = 1'b1;
    s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
    forever begin
      @(negedge clk);
      r   = rst;
      awh = s_awvalid & s_awready;
      wh  = s_wvalid & s_wready;
      bh  = s_bvalid & s_bready;
      arh = s_arvalid & s_arready;
      rh  = s_rvalid & s_rready;
      cap_aw = s_awaddr; cap_w = s_wdata; cap_ar = s_araddr;
      if (awh) begin aw_cnt++; last_awaddr = s_awaddr; end
      if (wh) begin last_wdata = s_wdata; last_wstrb = s_wstrb; end
      if (got_aw && s_awvalid) aw_reassert++;
      if (got_aw && s_wvalid && !s_wready) w_stall++;
      @(posedge clk); #1;
      if (r) begin
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        got_aw = 0; got_w = 0; wcnt = 0; rcnt = -1;
      end else begin
        if (bh) s_bvalid = 1'b0;
        if (rh) begin s_rvalid = 1'b0; s_rlast = 1'b0; end
        if (awh) begin got_aw = 1; saddr = cap_aw; if (split_mode) wcnt = 3; end
        else if (wcnt > 0) wcnt--;
        if (wh) begin got_w = 1; sdata = cap_w; end
        if (got_aw && got_w && !s_bvalid) begin
          mem[saddr] = sdata; s_bvalid = 1'b1; got_aw = 0; got_w = 0;
        end
        if (arh) begin raddr = cap_ar; rcnt = rdelay; end
        else if (rcnt > 0) rcnt--;
        if (rcnt == 0) begin
          s_rvalid = 1'b1; s_rlast = 1'b1; rcnt = -1;
          s_rdata  = mem.exists(raddr) ? mem[raddr] : {8'hA5, raddr};
        end
      end
      s_wready = split_mode ? (got_aw && !got_w && wcnt == 0) : 1'b1;
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    logic [N-1:0] act, gsel;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if ((m_bvalid[i] && m_bready[i]) || (m_rvalid[i] && m_rready[i])) begin
            chk("resp_expected_present", expq.size() != 0, 1);
            if (expq.size() != 0) begin
              e = expq.pop_front();
              chk("resp_kind", m_rvalid[i], e.rd);
              chk("resp_master", i, e.master);
              chk("resp_grant_id", grant_id, i);
              if (e.rd) begin
                chk("rdata", m_rdata, e.data);
                chk("rresp", m_rresp, 0);
              end else chk("bresp", m_bresp, 0);
            end
          end
        end
        if (busy) begin
          act  = m_awready | m_wready | m_arready | m_bvalid | m_rvalid;
          gsel = N'(1) << grant_id;
          chk("ungranted_quiet", act & ~gsel, 0);
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic mwrite(input int i, input logic [15:0] a, input logic [23:0] d);
    bit aw_ok, w_ok, b_ok;
    int n;
    m_awaddr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW]  = d;
    m_wstrb[i*4 +: 4]    = 4'hF;
    m_wlast[i]           = 1'b1;
    m_awvalid[i] = 1'b1;
    m_wvalid[i]  = 1'b1;
    aw_ok = 0; w_ok = 0; b_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 200) begin
      @(negedge clk);
      if (m_awvalid[i] && m_awready[i]) aw_ok = 1;
      if (m_wvalid[i] && m_wready[i]) w_ok = 1;
      @(posedge clk); #1;
      if (aw_ok) m_awvalid[i] = 1'b0;
      if (w_ok)  m_wvalid[i]  = 1'b0;
      n++;
    end
    chk("write_addr_data_timeout", aw_ok && w_ok, 1);
    m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
    n = 0;
    while (!b_ok && n < 200) begin
      @(negedge clk);
      b_ok = m_bvalid[i];
      @(posedge clk); #1;
      n++;
    end
    chk("write_resp_timeout", b_ok, 1);
  endtask

  task automatic mread(input int i, input logic [15:0] a);
    bit ar_ok, r_ok;
    int n;
    m_araddr[i*AW +: AW] = a;
    m_arvalid[i] = 1'b1;
    ar_ok = 0; r_ok = 0; n = 0;
    while (!ar_ok && n < 300) begin
      @(negedge clk);
      ar_ok = m_arready[i];
      @(posedge clk); #1;
      n++;
    end
    m_arvalid[i] = 1'b0;
    chk("read_addr_timeout", ar_ok, 1);
    n = 0;
    while (!r_ok && n < 200) begin
      @(negedge clk);
      r_ok = m_rvalid[i];
      @(posedge clk); #1;
      n++;
    end
    chk("read_resp_timeout", r_ok, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", expq.size() == 0 && !busy, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int aw0;
    rst = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_wlast = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    m_bready = '1; m_rready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_quiet", {busy, m_awready, m_wready, m_arready, m_bvalid, m_rvalid,
                         s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 0);
      chk("idle_grant_id", grant_id, 0);
    end
    @(posedge clk); #1;

    // single write then readback on master 0
    push_exp(0, 0, 24'h0);
    mwrite(0, 16'h0010, 24'h123456);
    drain();
    chk("single_s_awaddr", last_awaddr, 16'h0010);
    chk("single_s_wdata", last_wdata, 24'h123456);
    chk("single_s_wstrb", last_wstrb, 4'hF);
    push_exp(1, 0, 24'h123456);
    mread(0, 16'h0010);
    drain();

    // master 7 alone: pointer wraps back to 0
    push_exp(1, 7, 24'hA50077);
    mread(7, 16'h0077);
    drain();

    // round-robin among 0,3,7 holding requests
    push_exp(1, 0, 24'hA50100); push_exp(1, 3, 24'hA50103); push_exp(1, 7, 24'hA50107);
    push_exp(1, 0, 24'hA50200); push_exp(1, 3, 24'hA50203); push_exp(1, 7, 24'hA50207);
    fork
      begin mread(0, 16'h0100); mread(0, 16'h0200); end
      begin mread(3, 16'h0103); mread(3, 16'h0203); end
      begin mread(7, 16'h0107); mread(7, 16'h0207); end
    join
    drain();

    // master 2 write+read together, master 5 served in between
    push_exp(0, 2, 24'h0);
    push_exp(1, 5, 24'hA50050);
    push_exp(1, 2, 24'hABCDEF);
    fork
      mwrite(2, 16'h0020, 24'hABCDEF);
      mread(2, 16'h0020);
      mread(5, 16'h0050);
    join
    drain();

    // split AW/W: slave stalls W for 3 cycles after AW
    aw0 = aw_cnt;
    aw_reassert = 0;
    w_stall = 0;
    split_mode = 1'b1;
    @(posedge clk); #2;
    push_exp(0, 3, 24'h0);
    mwrite(3, 16'h0030, 24'h0F0F0F);
    drain();
    chk("split_aw_count", aw_cnt - aw0, 1);
    chk("split_aw_not_reasserted", aw_reassert, 0);
    chk("split_w_stall_cycles", w_stall, 3);
    split_mode = 1'b0;
    @(posedge clk); #2;
    push_exp(1, 3, 24'h0F0F0F);
    mread(3, 16'h0030);
    drain();

    // reset while waiting in the read response phase
    rdelay = 50;
    m_araddr[6*AW +: AW] = 16'h0060;
    m_arvalid[6] = 1'b1;
    begin
      bit ok;
      int n;
      ok = 0; n = 0;
      while (!ok && n < 50) begin
        @(negedge clk);
        ok = m_arready[6];
        @(posedge clk); #1;
        n++;
      end
      m_arvalid[6] = 1'b0;
      chk("midrd_ar_handshake", ok, 1);
    end
    @(negedge clk);
    chk("midrd_in_resp", {busy, s_rready, s_rvalid}, 3'b110);
    chk("midrd_grant_id", grant_id, 6);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rdelay = 0;
    @(negedge clk);
    chk("midrd_after_rst_quiet", {busy, m_rvalid, m_arready, s_rready, s_arvalid}, 0);
    chk("midrd_after_rst_grant", grant_id, 0);
    @(posedge clk); #1;
    // pointer back at 0 means master 2 beats master 4
    push_exp(1, 2, 24'h123456);
    push_exp(1, 4, 24'hA50040);
    fork
      mread(2, 16'h0010);
      mread(4, 16'h0040);
    join
    drain();

    chk("queue_empty_at_end", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
